// File: rtl/lookup3_key_packer.sv
// Packs a byte-serial key into 12-byte little-endian lookup3 blocks; block valid 1 cycle after its closing byte.
// Backpressure: a block is held stable until blk_ready, and input is stalled (in_ready=0) while it is held.
module lookup3_key_packer #(
   parameter int MAX_KEY_LEN = 250,
   parameter int LEN_W       = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   input  logic             in_empty,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [31:0]      blk_k0,
   output logic [31:0]      blk_k1,
   output logic [31:0]      blk_k2,
   output logic [3:0]       blk_bytes,
   output logic             blk_last,
   output logic             blk_err,
   output logic [LEN_W-1:0] key_len
);

   typedef enum logic [1:0] {FILL, HOLD, DROP} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_KEY_LEN);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state, state_nxt;
   logic [95:0]      kbuf;
   logic [3:0]       byte_cnt;
   logic [LEN_W-1:0] len_cnt;
   logic [3:0]       bytes_q;
   logic             last_q;
   logic             err_q;
   logic [LEN_W-1:0] key_len_q;

   logic pack;
   logic close;
   logic close_last;
   logic overflow;
   logic err_close;
   logic blk_take;

   assign blk_k0    = kbuf[31:0];
   assign blk_k1    = kbuf[63:32];
   assign blk_k2    = kbuf[95:64];
   assign blk_bytes = bytes_q;
   assign blk_last  = last_q;
   assign blk_err   = err_q;
   assign key_len   = key_len_q;
   assign blk_take  = blk_valid & blk_ready;

   always_ff @(posedge clk or negedge res) begin
      if (!res) state <= FILL;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      blk_valid  = 1'b0;
      pack       = 1'b0;
      close      = 1'b0;
      close_last = 1'b0;
      overflow   = 1'b0;
      err_close  = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // An empty marker closes whatever is buffered (possibly nothing) and carries no data.
               if (in_last && in_empty) begin
                  close      = 1'b1;
                  close_last = 1'b1;
               end else if (len_cnt == MAX_LEN) begin
                  overflow  = 1'b1;
                  err_close = in_last;
                  state_nxt = in_last ? HOLD : DROP;
               end else begin
                  pack = 1'b1;
                  if (in_last || byte_cnt == 4'd11) begin
                     close      = 1'b1;
                     close_last = in_last;
                  end
               end
               if (close) state_nxt = HOLD;
            end
         end
         HOLD: begin
            blk_valid = 1'b1;
            if (blk_ready) state_nxt = FILL;
         end
         DROP: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               err_close = 1'b1;
               state_nxt = HOLD;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         kbuf      <= '0;
         byte_cnt  <= '0;
         len_cnt   <= '0;
         bytes_q   <= '0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
         key_len_q <= '0;
      end else begin
         if (pack) begin
            for (int i = 0; i < 12; i++) begin
               if (byte_cnt == 4'(i)) kbuf[8*i +: 8] <= in_data;
            end
            byte_cnt <= byte_cnt + 4'd1;
            len_cnt  <= len_cnt + LEN_ONE;
         end
         if (close) begin
            bytes_q   <= pack ? byte_cnt + 4'd1 : byte_cnt;
            last_q    <= close_last;
            err_q     <= 1'b0;
            key_len_q <= close_last ? (pack ? len_cnt + LEN_ONE : len_cnt) : '0;
         end
         // The partial block is abandoned so the error block goes out all-zero.
         if (overflow) begin
            kbuf     <= '0;
            byte_cnt <= '0;
         end
         if (err_close) begin
            kbuf      <= '0;
            byte_cnt  <= '0;
            bytes_q   <= '0;
            last_q    <= 1'b1;
            err_q     <= 1'b1;
            key_len_q <= MAX_LEN;
         end
         if (blk_take) begin
            kbuf      <= '0;
            byte_cnt  <= '0;
            bytes_q   <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            key_len_q <= '0;
            if (last_q) len_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lookup3_key_packer.sv
// Directed bench for lookup3_key_packer with hand-computed block contents.
module tb_lookup3_key_packer;

   logic        clk;
   logic        res;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        in_empty;
   logic        blk_valid;
   logic        blk_ready;
   logic [31:0] blk_k0;
   logic [31:0] blk_k1;
   logic [31:0] blk_k2;
   logic [3:0]  blk_bytes;
   logic        blk_last;
   logic        blk_err;
   logic [7:0]  key_len;

   int n_vec = 0;
   int n_err = 0;

   // block handshake monitor (sampled mid-cycle)
   int          mon_full = 0;
   int          mon_fin  = 0;
   logic [31:0] mon_full_k0 = '0;
   logic [31:0] mon_fin_k0 = '0;
   logic [3:0]  mon_fin_bytes = '0;
   logic        mon_fin_err = 1'b0;
   logic [7:0]  mon_fin_len = '0;

   lookup3_key_packer #(.MAX_KEY_LEN(250), .LEN_W(8)) dut (
      .clk      (clk),
      .res      (res),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_empty (in_empty),
      .blk_valid(blk_valid),
      .blk_ready(blk_ready),
      .blk_k0   (blk_k0),
      .blk_k1   (blk_k1),
      .blk_k2   (blk_k2),
      .blk_bytes(blk_bytes),
      .blk_last (blk_last),
      .blk_err  (blk_err),
      .key_len  (key_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (blk_valid && blk_ready) begin
         if (blk_last) begin
            mon_fin++;
            mon_fin_k0    = blk_k0;
            mon_fin_bytes = blk_bytes;
            mon_fin_err   = blk_err;
            mon_fin_len   = key_len;
         end else if (blk_bytes == 4'd12) begin
            mon_full++;
            mon_full_k0 = blk_k0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte is accepted.
   task automatic send(input logic [7:0] d, input logic l, input logic e);
      int  n;
      logic acc;
      n = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      in_empty = e;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_empty = 1'b0;
   endtask

   task automatic send_str(input string s, input logic last_at_end);
      for (int i = 0; i < s.len(); i++)
         send(s[i], last_at_end && (i == s.len() - 1), 1'b0);
   endtask

   // Checks the held block, then takes it and checks the buffer clears.
   task automatic expect_blk(input string tag, input logic [31:0] k0, input logic [31:0] k1,
                             input logic [31:0] k2, input logic [3:0] bytes, input logic last,
                             input logic err, input logic [7:0] len);
      chk({tag, "_valid"}, 32'(blk_valid), 32'd1);
      chk({tag, "_k0"}, blk_k0, k0);
      chk({tag, "_k1"}, blk_k1, k1);
      chk({tag, "_k2"}, blk_k2, k2);
      chk({tag, "_bytes"}, 32'(blk_bytes), 32'(bytes));
      chk({tag, "_last"}, 32'(blk_last), 32'(last));
      chk({tag, "_err"}, 32'(blk_err), 32'(err));
      if (last) chk({tag, "_len"}, 32'(key_len), 32'(len));
      blk_ready = 1'b1;
      @(posedge clk);
      #1;
      blk_ready = 1'b0;
      chk({tag, "_done_valid"}, 32'(blk_valid), 32'd0);
      chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_done_k0"}, blk_k0, 32'd0);
   endtask

   task automatic long_key(input string tag, input int n);
      int base_full;
      int base_fin;
      int w;
      base_full = mon_full;
      base_fin  = mon_fin;
      blk_ready = 1'b1;
      for (int i = 1; i <= n; i++) send(8'(i), i == n, 1'b0);
      w = 0;
      while (mon_fin == base_fin && w < 20) begin
         @(posedge clk);
         #1;
         w++;
      end
      blk_ready = 1'b0;
      chk({tag, "_final_seen"}, 32'(mon_fin - base_fin), 32'd1);
      chk({tag, "_full_blocks"}, 32'(mon_full - base_full), 32'd20);
      chk({tag, "_blk20_k0"}, mon_full_k0, 32'he8e7e6e5);
      chk({tag, "_err_k0"}, mon_fin_k0, 32'd0);
      chk({tag, "_err_bytes"}, 32'(mon_fin_bytes), 32'd0);
      chk({tag, "_err_flag"}, 32'(mon_fin_err), 32'd1);
      chk({tag, "_err_len"}, 32'(mon_fin_len), 32'd250);
      @(posedge clk);
      #1;
      chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      res       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_empty  = 1'b0;
      blk_ready = 1'b0;
      #3;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_blk_valid", 32'(blk_valid), 32'd0);
      chk("rst_k0", blk_k0, 32'd0);
      chk("rst_k1", blk_k1, 32'd0);
      chk("rst_k2", blk_k2, 32'd0);
      chk("rst_bytes", 32'(blk_bytes), 32'd0);
      chk("rst_last", 32'(blk_last), 32'd0);
      chk("rst_err", 32'(blk_err), 32'd0);
      chk("rst_len", 32'(key_len), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      res = 1'b1;
      @(posedge clk);
      #1;

      // 12-byte key: one full final block, visible the cycle after the closing byte
      send_str("abcdefghijkl", 1'b1);
      chk("k12_in_ready_hold", 32'(in_ready), 32'd0);
      expect_blk("k12", 32'h64636261, 32'h68676665, 32'h6c6b6a69, 4'd12, 1'b1, 1'b0, 8'd12);

      send_str("abcde", 1'b1);
      expect_blk("k5", 32'h64636261, 32'h00000065, 32'h0, 4'd5, 1'b1, 1'b0, 8'd5);

      send_str("abcdefghijkl", 1'b0);
      expect_blk("k13a", 32'h64636261, 32'h68676665, 32'h6c6b6a69, 4'd12, 1'b0, 1'b0, 8'd0);
      send(8'h6d, 1'b1, 1'b0);
      expect_blk("k13b", 32'h0000006d, 32'h0, 32'h0, 4'd1, 1'b1, 1'b0, 8'd13);

      // empty key, consumer stalls for 5 cycles
      send(8'hff, 1'b1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         chk("empty_stall_valid", 32'(blk_valid), 32'd1);
         chk("empty_stall_in_ready", 32'(in_ready), 32'd0);
         chk("empty_stall_bytes", 32'(blk_bytes), 32'd0);
         chk("empty_stall_last", 32'(blk_last), 32'd1);
         @(posedge clk);
         #1;
      end
      expect_blk("empty", 32'h0, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 8'd0);

      // overflow on a last byte, then overflow through the drop state
      long_key("len251", 251);
      long_key("len252", 252);

      // mid-key reset discards buffered bytes
      send_str("abcdefg", 1'b0);
      res = 1'b0;
      #2;
      chk("mid_rst_valid", 32'(blk_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_k0", blk_k0, 32'd0);
      @(posedge clk);
      #1;
      res = 1'b1;
      @(posedge clk);
      #1;
      send_str("xy", 1'b1);
      expect_blk("xy", 32'h00007978, 32'h0, 32'h0, 4'd2, 1'b1, 1'b0, 8'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
